byte_stream_op_bridge: RTL
==========================

Name: byte_stream_op_bridge

Overview:
- Parametrised byte-serial front end for a TinyTapeout compute core, such as an FP multiplier.
- Assembles NUM_OPS operands of WORD_W bits from an 8-bit input stream and issues them to the core with a valid/ready handshake.
- Captures the core's RES_W-bit result and streams it back out one byte at a time, also with valid/ready.
- Adds over the previous generation: configurable widths and operand count, byte order, flow control on every interface, frame abort, and a completed-frame counter.

Parameters:
- WORD_W, 32, operand width in bits; multiple of 8, at least 8.
- NUM_OPS, 2, operands per frame; at least 1.
- RES_W, 32, result width in bits; multiple of 8, at least 8.
- MSB_FIRST, 0, byte order. 0: first byte is the LS byte of operand 0. 1: first byte is the MS byte of operand NUM_OPS-1, and the result is sent MS byte first.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- abort  input  1  synchronous frame abort, active-high.
- in_byte  input  8  input stream byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  bridge accepts in_byte this cycle.
- ops_data  output  NUM_OPS*WORD_W  packed operands; operand i occupies bits [i*WORD_W +: WORD_W].
- ops_valid  output  1  ops_data is valid for the core.
- ops_ready  input  1  core accepts the operands.
- res_data  input  RES_W  result from the core.
- res_valid  input  1  res_data is valid.
- res_ready  output  1  bridge accepts the result.
- out_byte  output  8  output stream byte.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  downstream accepts out_byte.
- busy  output  1  state is not LOAD, or at least one byte of the current frame has been received.
- frame_cnt  output  16  number of completed frames.

Behaviour:
- Derived constants:
  - IN_BYTES = NUM_OPS*WORD_W/8.
  - OUT_BYTES = RES_W/8.
- Counters:
  - byte index counter is clog2(max(IN_BYTES, OUT_BYTES)) bits, minimum 1.
- States: LOAD, ISSUE, WAIT_RES, DRAIN.
- Reset (rst=1):
  - state goes to LOAD; byte index, operand register, result register and frame_cnt go to 0.
  - While rst=1, every output is 0, including in_ready.
  - in_ready may first be 1 on the cycle after rst deasserts.
- Priority: rst > abort > normal operation.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready writes byte k, counting from 0:
    - MSB_FIRST=0: to bits [8k+7:8k].
    - MSB_FIRST=1: to bits [8(IN_BYTES-1-k)+7 : 8(IN_BYTES-1-k)].
  - When the accepted byte is byte IN_BYTES-1: go to ISSUE next cycle, index cleared.
  - in_ready drops in that next cycle.
- ISSUE:
  - ops_valid=1.
  - ops_data holds stable from the cycle after the last byte is accepted until the handshake completes.
  - On ops_valid&ops_ready: go to WAIT_RES; ops_valid=0 next cycle.
- WAIT_RES:
  - res_ready=1.
  - On res_valid: register res_data and go to DRAIN.
  - res_data is sampled only in that cycle.
- DRAIN:
  - out_valid=1.
  - out_byte is result byte j:
    - MSB_FIRST=0: bits [8j+7:8j].
    - MSB_FIRST=1: bits [8(OUT_BYTES-1-j)+7 : 8(OUT_BYTES-1-j)].
  - out_byte holds stable while out_ready=0.
  - On acceptance of byte OUT_BYTES-1: go to LOAD, increment frame_cnt (wraps 0xFFFF -> 0x0000), clear index.
  - in_ready=1 in the following cycle.
- Latencies:
  - last input byte accepted at cycle t -> ops_valid=1 at t+1.
  - result accepted at t -> out_valid=1 at t+1 with byte 0.
  - ops_ready and res_valid may both be tied high; then the minimum frame is IN_BYTES + 1 + 1 + OUT_BYTES cycles.
- Outside their states: ops_valid, res_ready, out_valid are 0; in_ready is 0 outside LOAD.
- Valid/ready handshakes are standard: a transfer occurs only when both are 1 in the same cycle; the bridge never drops a valid without a transfer.
- Abort (rst=0, abort=1), in any state:
  - next state is LOAD; index and operand register cleared; frame_cnt unchanged.
  - Any in_byte, ops, result or out handshake in the abort cycle is ignored: no state update, no frame_cnt increment.
  - All valid/ready outputs are forced to 0 during the abort cycle.
- Simultaneous events:
  - A result arriving while in DRAIN or ISSUE is not accepted (res_ready=0).
  - Back-to-back frames are allowed: a byte offered in the cycle after the last out byte is accepted.

Test Plan:
- Defaults, ops_ready=res_valid=out_ready=1, bytes 0x01..0x08 -> ops_data=0x0807060504030201, ops_valid one cycle after byte 0x08. res_data=0xAABBCCDD -> out bytes DD,CC,BB,AA; frame_cnt=1.
- MSB_FIRST=1, same bytes -> ops_data=0x0102030405060708. res_data=0xAABBCCDD -> out AA,BB,CC,DD.
- Backpressure: ops_ready low 5 cycles, out_ready toggling 1,0,0,1 -> ops_data stable and in_ready=0 throughout; each out byte held until accepted; no byte lost or duplicated.
- Abort after 3 of 8 bytes, then a full frame 0x10..0x17 -> ops_data=0x1716151413121110, frame_cnt unchanged by the abort. Abort during DRAIN -> out_valid=0 next cycle.
- rst asserted mid-DRAIN at frame_cnt=5 -> all outputs 0 during rst, frame_cnt=0; in_ready=1 the cycle after rst deasserts.
- WORD_W=16, NUM_OPS=3, RES_W=8 -> 6 input bytes map to 3 operands; single output byte; frame_cnt wrap from 0xFFFF to 0x0000 (preload via 65536 frames or forced).

Source files
------------

// File: rtl/byte_stream_op_bridge.sv
// Byte-serial front end for a compute core: gathers NUM_OPS operands of
// WORD_W bits from an 8-bit stream, hands them to the core over valid/ready,
// captures the RES_W-bit result and streams it back out one byte at a time.
module byte_stream_op_bridge #(
    parameter int WORD_W    = 32,
    parameter int NUM_OPS   = 2,
    parameter int RES_W     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      abort,
    input  logic [7:0]                in_byte,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NUM_OPS*WORD_W-1:0] ops_data,
    output logic                      ops_valid,
    input  logic                      ops_ready,
    input  logic [RES_W-1:0]          res_data,
    input  logic                      res_valid,
    output logic                      res_ready,
    output logic [7:0]                out_byte,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic [15:0]               frame_cnt
);

    localparam int OPS_W     = NUM_OPS * WORD_W;
    localparam int IN_BYTES  = OPS_W / 8;
    localparam int OUT_BYTES = RES_W / 8;
    localparam int MAX_BYTES = (IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES;
    localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(IN_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(OUT_BYTES - 1);

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [OPS_W-1:0]  ops_q, ops_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        out_sel;
    logic              live;

    // State and datapath registers; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            ops_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ops_q   <= ops_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; abort discards whatever handshake is offered this cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ops_d   = ops_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = LOAD;
            idx_d   = '0;
            ops_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        // Byte k lands at position k, or mirrored for MS-first streams.
                        for (int b = 0; b < IN_BYTES; b++) begin
                            if (idx_q == IDX_W'(MSB_FIRST ? (IN_BYTES - 1 - b) : b))
                                ops_d[8*b +: 8] = in_byte;
                        end
                        if (idx_q == LAST_IN) begin
                            state_d = ISSUE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (ops_ready) state_d = WAIT_RES;
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        res_d   = res_data;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx_q == LAST_OUT) begin
                            state_d = LOAD;
                            idx_d   = '0;
                            cnt_d   = cnt_q + 16'd1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // Pick the result byte addressed by the index in the configured byte order.
    always_comb begin
        out_sel = 8'h00;
        for (int j = 0; j < OUT_BYTES; j++) begin
            if (idx_q == IDX_W'(j))
                out_sel = res_q[8*(MSB_FIRST ? (OUT_BYTES - 1 - j) : j) +: 8];
        end
    end

    // Handshake outputs are state decodes, silenced during reset and abort;
    // data outputs read as zero while reset is held.
    always_comb begin
        live      = !rst && !abort;
        in_ready  = live && (state_q == LOAD);
        ops_valid = live && (state_q == ISSUE);
        res_ready = live && (state_q == WAIT_RES);
        out_valid = live && (state_q == DRAIN);
        ops_data  = rst ? '0 : ops_q;
        out_byte  = rst ? 8'h00 : out_sel;
        frame_cnt = rst ? 16'h0000 : cnt_q;
        busy      = !rst && ((state_q != LOAD) || (idx_q != '0));
    end

endmodule
